// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine cycle controller.
package wash_pkg;

  localparam int unsigned COUNT_W = 32;
  localparam int unsigned BASE_W  = 29;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FILLING  = 3'b001,
    WASHING  = 3'b010,
    RINSING  = 3'b011,
    SPINNING = 3'b100
  } wash_state_e;

  localparam logic [3:0] FREQ_1MHZ = 4'b0001;
  localparam logic [3:0] FREQ_2MHZ = 4'b0010;
  localparam logic [3:0] FREQ_4MHZ = 4'b0100;
  localparam logic [3:0] FREQ_8MHZ = 4'b1000;

  // Base count scaled by 2**shift; a zero base still yields a one-cycle phase.
  function automatic logic [COUNT_W-1:0] phase_target(input logic [BASE_W-1:0] base,
                                                      input logic [1:0]        shift);
    logic [COUNT_W-1:0] b;
    b = (base == '0) ? COUNT_W'(1) : COUNT_W'(base);
    return b << shift;
  endfunction

endpackage

// File: rtl/wash_cycle_controller_phase_timer.sv
// Phase timer: clearable, pausable up-counter flagging the last cycle of a phase.
module phase_timer
  import wash_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [COUNT_W-1:0] target,
  output logic [COUNT_W-1:0] count,
  output logic               terminal_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + COUNT_W'(1);
    end
  end

  assign terminal_c = (count == target - COUNT_W'(1));

endmodule

// File: rtl/wash_cycle_controller.sv
// Washing-machine sequencer: IDLE -> FILLING -> WASHING -> RINSING -> SPINNING.
// Define DOUBLE_WASH_EN to honour double_wash (second wash+rinse pass).
module wash_cycle_controller
  import wash_pkg::*;
#(
  parameter logic [28:0] FILLING_COUNT  = 29'd120000000,
  parameter logic [28:0] WASHING_COUNT  = 29'd300000000,
  parameter logic [28:0] RINSING_COUNT  = 29'd120000000,
  parameter logic [28:0] SPINNING_COUNT = 29'd60000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  clock_frequency,
  input  logic        coin_in,
  input  logic        double_wash,
  input  logic        timer_pause,
  output logic [2:0]  state,
  output logic        door_lock,
  output logic        wash_done,
  output logic [31:0] phase_count
);

  wash_state_e        state_q;
  logic [1:0]         shift_q;
  logic [1:0]         freq_shift_c;
  logic               freq_ok_c;
  logic [BASE_W-1:0]  base_c;
  logic [COUNT_W-1:0] target_c;
  logic               terminal_c;
  logic               paused_c;
  logic               advance_c;
  logic               second_pass_c;
  logic               start_c;

  // One-hot frequency select to a shift amount; anything else is rejected.
  always_comb begin
    freq_ok_c    = 1'b1;
    freq_shift_c = 2'd0;
    case (clock_frequency)
      FREQ_1MHZ: freq_shift_c = 2'd0;
      FREQ_2MHZ: freq_shift_c = 2'd1;
      FREQ_4MHZ: freq_shift_c = 2'd2;
      FREQ_8MHZ: freq_shift_c = 2'd3;
      default:   freq_ok_c    = 1'b0;
    endcase
  end

  always_comb begin
    base_c = BASE_W'(1);
    case (state_q)
      FILLING:  base_c = FILLING_COUNT;
      WASHING:  base_c = WASHING_COUNT;
      RINSING:  base_c = RINSING_COUNT;
      SPINNING: base_c = SPINNING_COUNT;
      default:  base_c = BASE_W'(1);
    endcase
  end

  assign target_c  = phase_target(base_c, shift_q);
  assign start_c   = (state_q == IDLE) && coin_in && freq_ok_c;
  assign paused_c  = (state_q == SPINNING) && timer_pause;
  assign advance_c = (state_q != IDLE) && !paused_c && terminal_c;

  phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      ((state_q == IDLE) || advance_c),
    .enable     (!paused_c),
    .target     (target_c),
    .count      (phase_count),
    .terminal_c (terminal_c)
  );

`ifdef DOUBLE_WASH_EN
  logic dw_q;
  logic pass_q;

  // Double-wash request is frozen at coin acceptance; pass_q marks the second pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dw_q   <= 1'b0;
      pass_q <= 1'b0;
    end else if (start_c) begin
      dw_q   <= double_wash;
      pass_q <= 1'b0;
    end else if ((state_q == RINSING) && advance_c && second_pass_c) begin
      pass_q <= 1'b1;
    end
  end

  assign second_pass_c = dw_q && !pass_q;
`else
  logic unused_double_wash;
  assign unused_double_wash = double_wash;
  assign second_pass_c      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= 2'd0;
      door_lock <= 1'b0;
      wash_done <= 1'b0;
    end else begin
      wash_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_q   <= FILLING;
            shift_q   <= freq_shift_c;
            door_lock <= 1'b1;
          end
        end
        FILLING:  if (advance_c) state_q <= WASHING;
        WASHING:  if (advance_c) state_q <= RINSING;
        RINSING:  if (advance_c) state_q <= second_pass_c ? WASHING : SPINNING;
        SPINNING: begin
          if (advance_c) begin
            state_q   <= IDLE;
            door_lock <= 1'b0;
            wash_done <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          door_lock <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed self-checking bench for wash_cycle_controller with short phase counts.
module tb_wash_cycle_controller;

  localparam int F_BASE = 3;
  localparam int W_BASE = 5;
  localparam int R_BASE = 3;
  localparam int S_BASE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  clock_frequency = 4'b0001;
  logic        coin_in = 1'b0;
  logic        double_wash = 1'b0;
  logic        timer_pause = 1'b0;
  logic [2:0]  state;
  logic        door_lock;
  logic        wash_done;
  logic [31:0] phase_count;

  int vectors = 0;
  int miscompares = 0;

  wash_cycle_controller #(
    .FILLING_COUNT  (29'(F_BASE)),
    .WASHING_COUNT  (29'(W_BASE)),
    .RINSING_COUNT  (29'(R_BASE)),
    .SPINNING_COUNT (29'(S_BASE))
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clock_frequency (clock_frequency),
    .coin_in         (coin_in),
    .double_wash     (double_wash),
    .timer_pause     (timer_pause),
    .state           (state),
    .door_lock       (door_lock),
    .wash_done       (wash_done),
    .phase_count     (phase_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int st, input int cnt, input int lock,
                            input int done);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".count"}, phase_count, 32'(cnt));
    check({tag, ".lock"},  32'(door_lock), 32'(lock));
    check({tag, ".done"},  32'(wash_done), 32'(done));
  endtask

  // Full cycle from a coin; pause_ph selects which phase code sees timer_pause
  // for pause_len cycles (0 = none). Only SPINNING is expected to stretch.
  task automatic wash_run(input string tag, input logic [3:0] freq, input int sh, input bit dbl,
                          input int pause_ph, input int pause_len);
    int ph[$];
    int ln[$];
    bit dbl_on;
`ifdef DOUBLE_WASH_EN
    dbl_on = dbl;
`else
    dbl_on = 1'b0;
`endif
    ph = {1, 2, 3};
    ln = {F_BASE << sh, W_BASE << sh, R_BASE << sh};
    if (dbl_on) begin
      ph.push_back(2); ln.push_back(W_BASE << sh);
      ph.push_back(3); ln.push_back(R_BASE << sh);
    end
    ph.push_back(4); ln.push_back(S_BASE << sh);

    @(negedge clk);
    clock_frequency = freq;
    coin_in = 1'b1;
    double_wash = dbl;
    @(posedge clk);
    foreach (ph[p]) begin
      for (int i = 0; i < ln[p]; i++) begin
        @(negedge clk);
        // Mid-cycle input changes must be ignored.
        coin_in = 1'b0;
        clock_frequency = 4'b1000;
        double_wash = ~dbl;
        check_outs($sformatf("%s.p%0d.i%0d", tag, p, i), ph[p], i, 1, 0);
        timer_pause = (ph[p] == pause_ph) && (pause_ph != 4) && (i < pause_len);
        if (ph[p] == 4 && pause_ph == 4 && i == 0) begin
          timer_pause = 1'b1;
          for (int k = 0; k < pause_len; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_outs($sformatf("%s.hold%0d", tag, k), 4, 0, 1, 0);
          end
          timer_pause = 1'b0;
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    timer_pause = 1'b0;
    check_outs({tag, ".end"}, 0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    check_outs({tag, ".after"}, 0, 0, 0, 0);
  endtask

  task automatic bad_freq(input string tag, input logic [3:0] freq);
    @(negedge clk);
    clock_frequency = freq;
    coin_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s.state%0d", tag, i), 32'(state), 32'd0);
      check($sformatf("%s.lock%0d", tag, i), 32'(door_lock), 32'd0);
    end
    coin_in = 1'b0;
    clock_frequency = 4'b0001;
  endtask

  initial begin
    // Reset held while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      coin_in = 1'(i & 1);
      clock_frequency = 4'b0001 << (i % 4);
      timer_pause = 1'(i >> 1);
      double_wash = ~double_wash;
      check_outs($sformatf("rst%0d", i), 0, 0, 0, 0);
    end
    @(negedge clk);
    coin_in = 1'b0;
    timer_pause = 1'b0;
    double_wash = 1'b0;
    clock_frequency = 4'b0001;
    rst_n = 1'b1;

    wash_run("x1",    4'b0001, 0, 1'b0, 0, 0);
    wash_run("x4",    4'b0100, 2, 1'b0, 0, 0);
    wash_run("x2",    4'b0010, 1, 1'b0, 0, 0);
    wash_run("pspin", 4'b0001, 0, 1'b0, 4, 4);
    wash_run("pwash", 4'b0001, 0, 1'b0, 2, 4);
    bad_freq("f0011", 4'b0011);
    bad_freq("f0000", 4'b0000);
    wash_run("dbl",   4'b0001, 0, 1'b1, 0, 0);

    // Reset while in WASHING: immediate IDLE, no completion pulse.
    @(negedge clk);
    clock_frequency = 4'b0001;
    coin_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    coin_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst.pre", 32'(state), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("midrst.async", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs($sformatf("midrst.hold%0d", i), 0, 0, 0, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("midrst.rel", 0, 0, 0, 0);
    wash_run("restart", 4'b0001, 0, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
